keypad_scan: RTL and testbench

- Upstream stage of the keypad entry path: scans the 3x3 matrix keypad, synchronises and debounces the column inputs, and presents one key code with a pressed level and a single-cycle press strobe.
- Feeds the digit-entry and key-list logic, which sample `button` on the rising edge of `bstate`.
- Rejects bounce and multi-key ghosting so that downstream logic sees exactly one event per physical press.

---
 rtl/keypad_scan.sv | 204 ++++++++++++++++++++
 tb/tb_keypad_scan.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan.sv
// keypad_scan: 3x3 matrix keypad scanner with column sync, frame debounce
// and ghost rejection. Optional auto-repeat under `define KEYPAD_REPEAT_EN.
//
// Ports:
//   hwclk, reset               clock, synchronous active-high reset
//   keypad_r1..r3 (out)        row drives, one high at a time
//   keypad_c1..c3 (in)         asynchronous column senses
//   button[3:0] (out)          last valid debounced key code 1..9
//   bstate (out)               high while a debounced key is held
//   press (out)                one-cycle strobe per new key (and repeats)
module keypad_scan #(
  parameter int SETTLE_CYCLES  = 1200,
  parameter int DEBOUNCE_SCANS = 8,
  parameter int REPEAT_DELAY   = 6000000,
  parameter int REPEAT_PERIOD  = 2400000
) (
  input  logic       hwclk,
  input  logic       reset,
  output logic       keypad_r1,
  output logic       keypad_r2,
  output logic       keypad_r3,
  input  logic       keypad_c1,
  input  logic       keypad_c2,
  input  logic       keypad_c3,
  output logic [3:0] button,
  output logic       bstate,
  output logic       press
);

  localparam int CW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [7:0] DB = 8'(DEBOUNCE_SCANS);
  localparam logic [3:0] BAD = 4'hF;

  if (SETTLE_CYCLES < 4 || DEBOUNCE_SCANS < 1 ||
      DEBOUNCE_SCANS > 255 || REPEAT_DELAY < 1 ||
      REPEAT_PERIOD < 1) begin : g_bad_param
    $error("keypad_scan: parameter out of range");
  end

  typedef enum logic [1:0] {
    SCAN_R1,
    SCAN_R2,
    SCAN_R3
  } state_e;

  state_e      state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]  rows_q;
  logic [2:0]  c_meta_q;
  logic [2:0]  c_sync_q;
  logic [8:0]  frame_q;
  logic        eval_q;

  logic [3:0]  cand_q, cand_d;
  logic [7:0]  stab_q, stab_d;
  logic [3:0]  deb_q, deb_d;
  logic [3:0]  button_q;
  logic        bstate_q;
  logic        press_q;
  logic [3:0]  raw;
  logic [3:0]  ones;
  logic        new_press;
  logic        rep_fire;

  assign keypad_r1 = rows_q[0];
  assign keypad_r2 = rows_q[1];
  assign keypad_r3 = rows_q[2];
  assign button    = button_q;
  assign bstate    = bstate_q;
  assign press     = press_q;

  // Two-flop synchroniser on the asynchronous column inputs.
  always_ff @(posedge hwclk) begin
    if (reset) begin
      c_meta_q <= '0;
      c_sync_q <= '0;
    end else begin
      c_meta_q <= {keypad_c3, keypad_c2, keypad_c1};
      c_sync_q <= c_meta_q;
    end
  end

  // Row scan: each row held SETTLE_CYCLES cycles, columns latched at
  // the terminal count into that row's slice of the frame.
  always_ff @(posedge hwclk) begin
    if (reset) begin
      state_q <= SCAN_R1;
      cnt_q   <= '0;
      rows_q  <= '0;
      frame_q <= '0;
      eval_q  <= 1'b0;
    end else begin
      eval_q <= 1'b0;
      unique case (state_q)
        SCAN_R1: rows_q <= 3'b001;
        SCAN_R2: rows_q <= 3'b010;
        SCAN_R3: rows_q <= 3'b100;
        default: rows_q <= 3'b000;
      endcase
      if (cnt_q == LAST) begin
        cnt_q <= '0;
        unique case (state_q)
          SCAN_R1: begin
            frame_q[2:0] <= c_sync_q;
            state_q      <= SCAN_R2;
            rows_q       <= 3'b010;
          end
          SCAN_R2: begin
            frame_q[5:3] <= c_sync_q;
            state_q      <= SCAN_R3;
            rows_q       <= 3'b100;
          end
          SCAN_R3: begin
            frame_q[8:6] <= c_sync_q;
            state_q      <= SCAN_R1;
            rows_q       <= 3'b001;
            eval_q       <= 1'b1;
          end
          default: begin
            state_q <= SCAN_R1;
            rows_q  <= 3'b001;
          end
        endcase
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Frame decode: none -> 0, one -> its code, several -> invalid.
  always_comb begin
    raw  = 4'd0;
    ones = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (frame_q[i]) begin
        ones = ones + 4'd1;
        raw  = 4'(i + 1);
      end
    end
    if (ones > 4'd1) raw = BAD;
  end

  always_comb begin
    cand_d = raw;
    stab_d = 8'd1;
    if (raw == cand_q) begin
      cand_d = cand_q;
      stab_d = (stab_q >= DB) ? DB : stab_q + 8'd1;
    end
    deb_d = deb_q;
    if (stab_d == DB && cand_d != deb_q && cand_d != BAD)
      deb_d = cand_d;
  end

  assign new_press = eval_q && (deb_d != deb_q) && (deb_d != 4'd0);

`ifdef KEYPAD_REPEAT_EN
  logic [31:0] hold_q;
  logic        first_q;
  logic        key_evt;

  // Any debounced change (new key or release) restarts the hold timer.
  assign key_evt = eval_q && (deb_d != deb_q);
  assign rep_fire = bstate_q && !key_evt &&
                    (first_q ? hold_q == 32'(REPEAT_DELAY - 1)
                             : hold_q == 32'(REPEAT_PERIOD - 1));

  always_ff @(posedge hwclk) begin
    if (reset || !bstate_q || key_evt) begin
      hold_q  <= '0;
      first_q <= 1'b1;
    end else if (rep_fire) begin
      hold_q  <= '0;
      first_q <= 1'b0;
    end else begin
      hold_q <= hold_q + 32'd1;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  always_ff @(posedge hwclk) begin
    if (reset) begin
      cand_q   <= '0;
      stab_q   <= '0;
      deb_q    <= '0;
      button_q <= '0;
      bstate_q <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      press_q <= new_press | rep_fire;
      if (eval_q) begin
        cand_q   <= cand_d;
        stab_q   <= stab_d;
        deb_q    <= deb_d;
        bstate_q <= (deb_d != 4'd0);
        if (new_press) button_q <= deb_d;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: frame-level model of keypad_scan with directed key
// patterns; compares rows and outputs every cycle.
module tb_keypad_scan;

  logic       hwclk = 1'b0;
  logic       reset = 1'b1;
  logic       r1, r2, r3;
  logic       c1, c2, c3;
  logic [3:0] button;
  logic       bstate, press;
  logic [8:0] keys = '0;

  localparam logic [8:0] K1 = 9'b000000001;
  localparam logic [8:0] K5 = 9'b000010000;
  localparam logic [8:0] K7 = 9'b001000000;
  localparam logic [8:0] K9 = 9'b100000000;

  always #5 hwclk = ~hwclk;

  // Key bit 3*r+c connects row r to column c.
  assign c1 = (r1 & keys[0]) | (r2 & keys[3]) | (r3 & keys[6]);
  assign c2 = (r1 & keys[1]) | (r2 & keys[4]) | (r3 & keys[7]);
  assign c3 = (r1 & keys[2]) | (r2 & keys[5]) | (r3 & keys[8]);

  keypad_scan #(
    .SETTLE_CYCLES (4),
    .DEBOUNCE_SCANS(3)
  ) dut (
    .hwclk    (hwclk),
    .reset    (reset),
    .keypad_r1(r1),
    .keypad_r2(r2),
    .keypad_r3(r3),
    .keypad_c1(c1),
    .keypad_c2(c2),
    .keypad_c3(c3),
    .button   (button),
    .bstate   (bstate),
    .press    (press)
  );

  int checks = 0;
  int errors = 0;
  int npress = 0;

  int         cyc = 0;
  logic [8:0] snap = '0;
  logic [3:0] m_cand = '0;
  int         m_cnt = 0;
  logic [3:0] m_deb = '0;
  logic [3:0] e_btn = '0;
  logic       e_bst = 1'b0;
  logic       e_prs = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Rows after k cycles out of reset: 12-cycle frame, row1 from k=1.
  function automatic int exp_rows(input int k);
    int p;
    if (k == 0) return 0;
    p = k % 12;
    if (p < 4) return 1;
    if (p < 8) return 2;
    return 4;
  endfunction

  task automatic model_frame();
    int   n;
    logic [3:0] r;
    n = $countones(snap);
    r = 4'd0;
    for (int i = 0; i < 9; i++)
      if (snap[i]) r = 4'(i + 1);
    if (n > 1) r = 4'hF;
    if (r == m_cand) begin
      if (m_cnt < 3) m_cnt++;
    end else begin
      m_cand = r;
      m_cnt  = 1;
    end
    if (m_cnt == 3 && m_cand != m_deb && m_cand != 4'hF) begin
      m_deb = m_cand;
      if (m_deb != 0) begin
        e_btn = m_deb;
        e_prs = 1'b1;
      end
    end
    e_bst = (m_deb != 0);
  endtask

  // Frame j keys are snapshotted at cycle 12j; its result is visible
  // from cycle 12j+1.
  initial begin
    forever begin
      @(posedge hwclk);
      if (reset) begin
        cyc = 0; m_cand = 0; m_cnt = 0; m_deb = 0;
        e_btn = 0; e_bst = 0; e_prs = 0;
      end else begin
        cyc++;
        e_prs = 1'b0;
        if (cyc > 12 && cyc % 12 == 1) model_frame();
        if (cyc % 12 == 0) snap = keys;
      end
    end
  end

  initial begin
    forever begin
      @(negedge hwclk);
      chk("rows", int'({r3, r2, r1}), exp_rows(cyc));
      chk("button", int'(button), int'(e_btn));
      chk("bstate", int'(bstate), int'(e_bst));
      chk("press", int'(press), int'(e_prs));
      if (press) npress++;
    end
  end

  // Called just after cycle 12(j-1)+1; returns just after 12j+1,
  // when frame j's outputs are visible.
  task automatic run_frame(input logic [8:0] k);
    keys = k;
    repeat (12) @(posedge hwclk);
    @(negedge hwclk);
    #1;
  endtask

  task automatic start_scan();
    @(negedge hwclk);
    reset = 1'b0;
    @(posedge hwclk);
    @(negedge hwclk);
    #1;
  endtask

  int p0;

  initial begin
    repeat (3) @(posedge hwclk);
    start_scan();

    repeat (9) run_frame('0);
    chk("idle_press", npress, 0);
    chk("idle_button", int'(button), 0);

    p0 = npress;
    run_frame(K5);
    run_frame(K5);
    chk("k5_f2_bstate", int'(bstate), 0);
    run_frame(K5);
    chk("k5_f3_press", int'(press), 1);
    chk("k5_f3_button", int'(button), 5);
    run_frame(K5);
    run_frame(K5);
    chk("k5_presses", npress - p0, 1);
    chk("k5_bstate", int'(bstate), 1);

    p0 = npress;
    run_frame('0);
    run_frame('0);
    chk("rel5_f2_bstate", int'(bstate), 1);
    run_frame('0);
    chk("rel5_bstate", int'(bstate), 0);
    chk("rel5_button", int'(button), 5);
    chk("rel5_presses", npress - p0, 0);

    p0 = npress;
    for (int i = 0; i < 4; i++) begin
      run_frame(K1);
      run_frame('0);
    end
    chk("bounce_presses", npress - p0, 0);
    chk("bounce_bstate", int'(bstate), 0);
    repeat (3) run_frame(K1);
    chk("k1_presses", npress - p0, 1);
    chk("k1_button", int'(button), 1);

    repeat (3) run_frame('0);
    chk("rel1_bstate", int'(bstate), 0);

    p0 = npress;
    repeat (4) run_frame(K1 | K9);
    chk("ghost_presses", npress - p0, 0);
    chk("ghost_bstate", int'(bstate), 0);
    chk("ghost_button", int'(button), 1);
    repeat (3) run_frame(K1);
    chk("deghost_presses", npress - p0, 1);
    chk("deghost_button", int'(button), 1);
    chk("deghost_bstate", int'(bstate), 1);

    repeat (3) run_frame('0);

    p0 = npress;
    run_frame(K7);
    keys = K7;
    repeat (5) @(posedge hwclk);
    @(negedge hwclk);
    reset = 1'b1;
    @(posedge hwclk);
    @(negedge hwclk);
    #1;
    chk("rst_button", int'(button), 0);
    chk("rst_bstate", int'(bstate), 0);
    chk("rst_rows", int'({r3, r2, r1}), 0);
    chk("rst_presses", npress - p0, 0);
    start_scan();
    run_frame(K7);
    run_frame(K7);
    chk("k7_f2_presses", npress - p0, 0);
    run_frame(K7);
    chk("k7_press", int'(press), 1);
    chk("k7_button", int'(button), 7);
    chk("k7_presses", npress - p0, 1);

    repeat (2) run_frame('0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
